// File: rtl/arb64x4_rr.sv
// rtl/arb64x4_rr.sv - four-requester round-robin arbiter feeding a single registered output stage
module arb64x4_rr #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] w0,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] w3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       out_src
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_out;
    logic [1:0]       r_src;

    logic             w_can_accept;
    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;
    logic             w_grant;
    logic [WIDTH-1:0] w_mux;

    assign w_can_accept = (r_state == ST_EMPTY) | out_ready;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps 3 -> 0 on its own.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_grant = w_can_accept & w_found;

    always_comb begin
        gnt = 4'b0000;
        if (w_grant && !reset) begin
            gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_mux = '0;
        case (w_winner)
            2'd0: w_mux = w0;
            2'd1: w_mux = w1;
            2'd2: w_mux = w2;
            2'd3: w_mux = w3;
            default: w_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant while FULL replaces the word in place, so FULL only drains when nothing wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_grant) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_src <= 2'd0;
            r_ptr <= 2'd0;
        end else if (w_grant) begin
            r_out <= w_mux;
            r_src <= w_winner;
            r_ptr <= w_winner + 2'd1;
        end
    end

    assign out       = r_out;
    assign out_valid = (r_state == ST_FULL);
    assign out_src   = r_src;

endmodule

// File: tb/tb_arb64x4_rr.sv
// tb/tb_arb64x4_rr.sv - directed and randomised scoreboard bench for arb64x4_rr
module tb_arb64x4_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] w0, w1, w2, w3;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [63:0] out;
    logic        out_valid;
    logic [1:0]  out_src;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];
    logic [63:0] exp_word;
    logic [3:0]  exp_gnt;
    int          word_ctr;

    arb64x4_rr #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [63:0] word_of(input logic [1:0] idx);
        case (idx)
            2'd0: return w0;
            2'd1: return w1;
            2'd2: return w2;
            default: return w3;
        endcase
    endfunction

    initial begin
        reset = 1'b1; req = 4'b0; out_ready = 1'b0;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
        @(posedge clk); #1;
        #1;
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_src", {62'b0, out_src}, 64'd0);
        req = 4'b1111; #1;
        check("rst_gnt", {60'b0, gnt}, 64'd0);
        req = 4'b0;
        reset = 1'b0;
        step();

        // Two requesters, pointer advances past the first winner
        req = 4'b1010; w1 = 64'h11; w3 = 64'h33; out_ready = 1'b1; #1;
        check("v27_gnt1", {60'b0, gnt}, 64'b0010);
        step();
        check("v27_out1", out, 64'h11);
        check("v27_src1", {62'b0, out_src}, 64'd1);
        check("v27_gnt3", {60'b0, gnt}, 64'b1000);
        step();
        check("v27_out3", out, 64'h33);
        check("v27_src3", {62'b0, out_src}, 64'd3);
        req = 4'b0;
        step();
        check("v27_drain", {63'b0, out_valid}, 64'd0);

        // Full rotation with all requesters held
        do_reset();
        req = 4'b1111; w0 = 64'd0; w1 = 64'd1; w2 = 64'd2; w3 = 64'd3; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_gnt = 4'b0001 << (k % 4);
            check("v28_gnt", {60'b0, gnt}, {60'b0, exp_gnt});
            step();
            check("v28_src", {62'b0, out_src}, 64'(k % 4));
            check("v28_out", out, 64'(k % 4));
            check("v28_valid", {63'b0, out_valid}, 64'd1);
        end

        // Backpressure holds the word, grant appears as soon as ready returns
        do_reset();
        req = 4'b0001; w0 = 64'hA; out_ready = 1'b1;
        step();
        req = 4'b0100; w2 = 64'h22; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("v29_gnt_stall", {60'b0, gnt}, 64'd0);
            step();
            check("v29_out_hold", out, 64'hA);
            check("v29_valid_hold", {63'b0, out_valid}, 64'd1);
            check("v29_src_hold", {62'b0, out_src}, 64'd0);
        end
        out_ready = 1'b1; #1;
        check("v29_gnt_go", {60'b0, gnt}, 64'b0100);
        step();
        check("v29_out_new", out, 64'h22);
        check("v29_src_new", {62'b0, out_src}, 64'd2);

        // Drain to EMPTY keeps the last word, then a fresh request refills
        req = 4'b0; #1;
        check("v30_gnt0", {60'b0, gnt}, 64'd0);
        step();
        check("v30_valid_fall", {63'b0, out_valid}, 64'd0);
        check("v30_out_keep", out, 64'h22);
        req = 4'b0001; w0 = 64'h55; #1;
        check("v30_gnt", {60'b0, gnt}, 64'b0001);
        step();
        check("v30_valid_rise", {63'b0, out_valid}, 64'd1);
        check("v30_out", out, 64'h55);
        req = 4'b1111;

        // Asynchronous reset mid-cycle while FULL
        #2;
        reset = 1'b1;
        #1;
        check("v31_valid", {63'b0, out_valid}, 64'd0);
        check("v31_out", out, 64'd0);
        check("v31_gnt", {60'b0, gnt}, 64'd0);
        reset = 1'b0;
        #1;
        check("v31_first_gnt", {60'b0, gnt}, 64'b0001);
        req = 4'b0;
        step();

        // Randomised traffic against a grant-order scoreboard
        do_reset();
        sb_q.delete();
        word_ctr = 0;
        req = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && ($urandom_range(0, 2) != 0)) begin
                    req[i] = 1'b1;
                    word_ctr++;
                    case (i)
                        0: w0 = {8'h0, 24'h0, 32'(word_ctr)};
                        1: w1 = {8'h1, 24'h0, 32'(word_ctr)};
                        2: w2 = {8'h2, 24'h0, 32'(word_ctr)};
                        default: w3 = {8'h3, 24'h0, 32'(word_ctr)};
                    endcase
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd_onehot", 64'($countones(gnt) <= 1), 64'd1);
            check("rnd_gnt_req", {60'b0, gnt & ~req}, 64'd0);
            check("rnd_gnt_when", 64'(gnt != 4'b0),
                  64'(((!out_valid) || out_ready) && (req != 4'b0)));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rnd_unexpected", out, 64'hDEAD);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("rnd_order", out, exp_word);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    sb_q.push_back(word_of(2'(i)));
                end
            end
            exp_gnt = gnt;
            step();
            req = req & ~exp_gnt;
        end
        req = 4'b0; out_ready = 1'b1;
        #1;
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("rnd_tail_unexpected", out, 64'hDEAD);
            end else begin
                exp_word = sb_q.pop_front();
                check("rnd_tail", out, exp_word);
            end
        end
        step();
        check("rnd_empty_valid", {63'b0, out_valid}, 64'd0);
        check("rnd_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
